mem_read_unit: RTL and testbench



---
 rtl/mem_read_pkg.sv | 24 ++
 rtl/mem_read_timeout_ctr.sv | 34 +++
 rtl/mem_read_unit.sv | 118 +++++++++++
 tb/tb_mem_read_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_pkg.sv
// mem_read_pkg: shared definitions for the memory read unit.
//   state_e     : FSM state encoding (IDLE=00, REQ=01, DONE=10)
//   DEF_*       : default data/address widths and timeout depth
//   Q_RESET     : reset value of the captured data register
//   ctr_width() : width of the timeout counter for a given TIMEOUT
package mem_read_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_ADDR_W  = 9;
    localparam int unsigned DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [31:0] Q_RESET = 32'h0000_0000;

    function automatic int unsigned ctr_width(input int unsigned timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/mem_read_timeout_ctr.sv
// mem_read_timeout_ctr: saturating wait-cycle counter for the read unit.
//   clk    : system clock
//   clr    : synchronous active-high reset
//   clear  : restart counting from zero
//   enable : count one cycle (ignored while clear is high)
//   expire : high while the count equals TIMEOUT-1
module mem_read_timeout_ctr
    import mem_read_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = ctr_width(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (clr || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            // Saturate at all-ones instead of wrapping back to zero.
            count <= count + 1'b1;
        end
    end

    assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_read_unit.sv
// mem_read_unit: handshaken memory reader. A start in IDLE latches addr,
// raises mem_rd until mem_ack, captures mem_data into Q, then pulses done.
//   clk      : system clock
//   clr      : synchronous active-high reset
//   start    : read request (sampled in IDLE only)
//   addr     : read address (sampled with start)
//   mem_addr : address presented to RAM
//   mem_rd   : read strobe to RAM (high in REQ)
//   mem_ack  : RAM acknowledge, mem_data valid in the same cycle
//   mem_data : read data from RAM
//   Q        : captured data register
//   busy     : high whenever the FSM is not IDLE
//   done     : one-cycle completion pulse (DONE state)
//   err      : timeout flag
// Optional: define MEM_READ_TIMEOUT_EN to abandon a read after TIMEOUT
// REQ cycles without acknowledge; otherwise REQ waits forever, err=0.
module mem_read_unit
    import mem_read_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] Q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_DONE = DONE;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_read_unit: TIMEOUT must be >= 2");
    end

    logic [1:0] state;
    logic [1:0] state_next;
    logic       accept;
    logic       capture;
    logic       timeout_hit;

    assign accept  = (state == ST_IDLE) && start;
    assign capture = (state == ST_REQ) && mem_ack;

`ifdef MEM_READ_TIMEOUT_EN
    logic expire;
    logic err_q;

    mem_read_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk),
        .clr    (clr),
        .clear  (accept),
        .enable ((state == ST_REQ) && !mem_ack),
        .expire (expire)
    );

    // An acknowledge in the expiring cycle takes priority over the timeout.
    assign timeout_hit = (state == ST_REQ) && !mem_ack && expire;

    always_ff @(posedge clk) begin
        if (clr || accept) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_REQ;
            ST_REQ:  if (mem_ack || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            Q        <= DATA_W'(Q_RESET);
        end else begin
            state <= state_next;
            if (accept) begin
                mem_addr <= addr;
            end
            if (capture) begin
                Q <= mem_data;
            end
        end
    end

    // Strobes decode from state alone, so mem_ack never reaches an output
    // combinationally.
    assign mem_rd = (state == ST_REQ);
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_mem_read_unit.sv
// tb_mem_read_unit: directed self-checking bench for mem_read_unit.
// Inputs change 1 time unit after a rising edge; outputs are checked at
// that same point, well away from the next active edge.
module tb_mem_read_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  addr = '0;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] Q;
    logic        busy;
    logic        done;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mem_read_unit #(
        .DATA_W  (32),
        .ADDR_W  (9),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .addr     (addr),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .Q        (Q),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed status {busy, done, mem_rd, err} keeps the per-cycle checks short.
    task automatic test_reset();
        clr = 1'b1; start = 1'b1; addr = 9'h155;
        tick(); tick();
        clr = 1'b0; start = 1'b0;
        n_checks++;
        if (Q !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h expected %h", Q, 32'h0); end
        n_checks++;
        if (mem_addr !== 9'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", mem_addr, 9'h0); end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({busy, done, mem_rd, err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %b expected %b", i, {busy, done, mem_rd, err}, 4'b0000);
            end
            tick();
        end
    endtask

    task automatic test_zero_wait();
        start = 1'b1; addr = 9'h012;
        tick();                                   // edge N: now in REQ
        start = 1'b0; addr = 9'h000;
        mem_ack = 1'b1; mem_data = 32'h1111_1111;
        n_checks++;
        if ({busy, done, mem_rd} !== 3'b101) begin n_fail++; $display("FAIL zw_req: got %b expected %b", {busy, done, mem_rd}, 3'b101); end
        n_checks++;
        if (mem_addr !== 9'h012) begin n_fail++; $display("FAIL zw_addr: got %h expected %h", mem_addr, 9'h012); end
        n_checks++;
        if (Q !== 32'h0) begin n_fail++; $display("FAIL zw_q_old: got %h expected %h", Q, 32'h0); end
        tick();                                   // edge N+1: captured, DONE
        mem_ack = 1'b0; mem_data = 32'hCAFE_F00D;
        n_checks++;
        if ({busy, done, mem_rd} !== 3'b110) begin n_fail++; $display("FAIL zw_done: got %b expected %b", {busy, done, mem_rd}, 3'b110); end
        n_checks++;
        if (Q !== 32'h1111_1111) begin n_fail++; $display("FAIL zw_q: got %h expected %h", Q, 32'h1111_1111); end
        tick();                                   // edge N+2: IDLE
        n_checks++;
        if ({busy, done, mem_rd} !== 3'b000) begin n_fail++; $display("FAIL zw_idle: got %b expected %b", {busy, done, mem_rd}, 3'b000); end
        n_checks++;
        if (Q !== 32'h1111_1111) begin n_fail++; $display("FAIL zw_q_hold: got %h expected %h", Q, 32'h1111_1111); end
    endtask

    task automatic test_wait_states();
        start = 1'b1; addr = 9'h0A5;
        tick();
        addr = 9'h1C3;
        for (int i = 1; i <= 4; i++) begin
            start    = (i == 2);                  // mid-REQ start must be ignored
            mem_ack  = (i == 4);
            mem_data = (i == 4) ? 32'h1111_0000 : 32'hBAD0_0000;
            n_checks++;
            if ({mem_rd, done} !== 2'b10) begin n_fail++; $display("FAIL ws_rd[%0d]: got %b expected %b", i, {mem_rd, done}, 2'b10); end
            n_checks++;
            if (mem_addr !== 9'h0A5) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h expected %h", i, mem_addr, 9'h0A5); end
            tick();
        end
        start = 1'b0; mem_ack = 1'b0;
        n_checks++;
        if ({busy, done, mem_rd} !== 3'b110) begin n_fail++; $display("FAIL ws_done: got %b expected %b", {busy, done, mem_rd}, 3'b110); end
        n_checks++;
        if (Q !== 32'h1111_0000) begin n_fail++; $display("FAIL ws_q: got %h expected %h", Q, 32'h1111_0000); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({busy, done, mem_rd} !== 3'b000) begin n_fail++; $display("FAIL ws_no_reissue[%0d]: got %b expected %b", i, {busy, done, mem_rd}, 3'b000); end
        end
        n_checks++;
        if (mem_addr !== 9'h0A5) begin n_fail++; $display("FAIL ws_addr_hold: got %h expected %h", mem_addr, 9'h0A5); end
    endtask

`ifdef MEM_READ_TIMEOUT_EN
    task automatic test_timeout();
        start = 1'b1; addr = 9'h044;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            n_checks++;
            if ({mem_rd, done, err} !== 3'b100) begin n_fail++; $display("FAIL to_wait[%0d]: got %b expected %b", i, {mem_rd, done, err}, 3'b100); end
            tick();
        end
        n_checks++;
        if ({mem_rd, done, err} !== 3'b011) begin n_fail++; $display("FAIL to_expire: got %b expected %b", {mem_rd, done, err}, 3'b011); end
        n_checks++;
        if (Q !== 32'h1111_0000) begin n_fail++; $display("FAIL to_q_kept: got %h expected %h", Q, 32'h1111_0000); end
        tick(); tick();
        n_checks++;
        if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL to_err_hold: got %b expected %b", {busy, err}, 2'b01); end
        start = 1'b1; addr = 9'h045;
        tick();
        start = 1'b0; mem_ack = 1'b1; mem_data = 32'h2222_2222;
        n_checks++;
        if ({mem_rd, err} !== 2'b10) begin n_fail++; $display("FAIL to_err_clear: got %b expected %b", {mem_rd, err}, 2'b10); end
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if (Q !== 32'h2222_2222) begin n_fail++; $display("FAIL to_next_q: got %h expected %h", Q, 32'h2222_2222); end
        tick();
    endtask
`else
    task automatic test_timeout();
        start = 1'b1; addr = 9'h044;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            n_checks++;
            if ({mem_rd, done, err} !== 3'b100) begin n_fail++; $display("FAIL nt_wait[%0d]: got %b expected %b", i, {mem_rd, done, err}, 3'b100); end
            tick();
        end
        mem_ack = 1'b1; mem_data = 32'h0000_ABCD;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL nt_done: got %b expected %b", {done, err}, 2'b10); end
        n_checks++;
        if (Q !== 32'h0000_ABCD) begin n_fail++; $display("FAIL nt_q: got %h expected %h", Q, 32'h0000_ABCD); end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        start = 1'b1; addr = 9'h033;
        tick();
        start = 1'b0;
        tick();                                   // 2nd REQ cycle
        n_checks++;
        if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rm_req2: got %b expected %b", mem_rd, 1'b1); end
        clr = 1'b1; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        clr = 1'b0; mem_ack = 1'b0;
        n_checks++;
        if (Q !== 32'h0) begin n_fail++; $display("FAIL rm_q: got %h expected %h", Q, 32'h0); end
        n_checks++;
        if ({busy, done, mem_rd, err} !== 4'b0000) begin n_fail++; $display("FAIL rm_state: got %b expected %b", {busy, done, mem_rd, err}, 4'b0000); end
        n_checks++;
        if (mem_addr !== 9'h0) begin n_fail++; $display("FAIL rm_addr: got %h expected %h", mem_addr, 9'h0); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %b expected %b", done, 1'b0); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; addr = 9'h100;
        tick();
        start = 1'b0; mem_ack = 1'b1; mem_data = 32'h3333_3333;
        tick();                                   // DONE
        mem_ack = 1'b0;
        start = 1'b1; addr = 9'h1FF;              // ignored in DONE
        n_checks++;
        if (Q !== 32'h3333_3333) begin n_fail++; $display("FAIL bb_q1: got %h expected %h", Q, 32'h3333_3333); end
        tick();                                   // IDLE
        n_checks++;
        if ({busy, mem_rd} !== 2'b00) begin n_fail++; $display("FAIL bb_idle: got %b expected %b", {busy, mem_rd}, 2'b00); end
        n_checks++;
        if (mem_addr !== 9'h100) begin n_fail++; $display("FAIL bb_addr_old: got %h expected %h", mem_addr, 9'h100); end
        tick();                                   // start accepted in IDLE
        start = 1'b0; mem_ack = 1'b1; mem_data = 32'h4444_4444;
        n_checks++;
        if ({busy, mem_rd} !== 2'b11) begin n_fail++; $display("FAIL bb_req: got %b expected %b", {busy, mem_rd}, 2'b11); end
        n_checks++;
        if (mem_addr !== 9'h1FF) begin n_fail++; $display("FAIL bb_addr_new: got %h expected %h", mem_addr, 9'h1FF); end
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({done, Q} !== {1'b1, 32'h4444_4444}) begin n_fail++; $display("FAIL bb_q2: got %b/%h expected 1/%h", done, Q, 32'h4444_4444); end
        tick();                                   // IDLE: ack here must not load Q
        mem_ack = 1'b1; mem_data = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({busy, Q} !== {1'b0, 32'h4444_4444}) begin n_fail++; $display("FAIL bb_idle_ack: got %b/%h expected 0/%h", busy, Q, 32'h4444_4444); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
